mem_port_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the core's instruction-fetch port and its load/store port.

---
 rtl/rv_mem_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared types for the unified-memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Default memory word width and its byte-enable width.
    localparam int MEM_DATA_W = 32;
    localparam int STRB_W     = MEM_DATA_W / 8;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and load/store; MEM_ARB_RR_EN selects round-robin.
// Latency: combinational.
// Backpressure: none; caller only acts on grants while it is idle.
module mem_arb_pick
    import rv_mem_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             if_vld,
    input  logic             d_vld,
    input  owner_t           last_owner,
    input  logic [CNT_W-1:0] starve_cnt,
    output logic             grant_if,
    output logic             grant_d
);

`ifdef MEM_ARB_RR_EN
    // Starvation counter has no role under round-robin.
    logic unused_starve;
    assign unused_starve = ^starve_cnt;

    // On a tie the port that did not win last time takes the grant.
    always_comb begin
        grant_if = if_vld && (!d_vld || (last_owner == OWN_D));
        grant_d  = d_vld && !grant_if;
    end
`else
    // Last owner has no role under fixed priority.
    logic unused_last;
    assign unused_last = (last_owner == OWN_D);

    // Data wins ties unless fetch has been passed over STARVE_MAX times.
    always_comb begin
        grant_if = if_vld && (!d_vld || (starve_cnt == CNT_W'(STARVE_MAX)));
        grant_d  = d_vld && !grant_if;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch and load/store; MEM_ARB_RR_EN = round-robin.
// Latency: accept T, m_req_valid T+1, rsp pulse T+3 with zero-wait memory.
// Backpressure: one transaction in flight; req_ready only pulses while idle, REQ waits on m_req_ready.
module mem_port_arbiter
    import rv_mem_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [ADDR_W-1:0]   if_req_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rsp_data,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [ADDR_W-1:0]   d_req_addr,
    input  logic                d_req_we,
    input  logic [DATA_W/8-1:0] d_req_wstrb,
    input  logic [DATA_W-1:0]   d_req_wdata,
    output logic                d_rsp_valid,
    output logic [DATA_W-1:0]   d_rsp_data,
    output logic                m_req_valid,
    input  logic                m_req_ready,
    output logic [ADDR_W-1:0]   m_req_addr,
    output logic                m_req_we,
    output logic [DATA_W/8-1:0] m_req_wstrb,
    output logic [DATA_W-1:0]   m_req_wdata,
    input  logic                m_rsp_valid,
    input  logic [DATA_W-1:0]   m_rsp_data,
    output logic                busy
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    arb_state_t       state;
    arb_state_t       state_nxt;
    owner_t           owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             grant_if;
    logic             grant_d;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_pick (
        .if_vld     (if_req_valid),
        .d_vld      (d_req_valid),
        .last_owner (owner),
        .starve_cnt (starve_cnt),
        .grant_if   (grant_if),
        .grant_d    (grant_d)
    );

    assign m_req_valid = (state == REQ);
    assign busy        = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and accept pulses; ready is held low while reset is asserted.
    always_comb begin
        state_nxt    = state;
        if_req_ready = 1'b0;
        d_req_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (!reset && (grant_if || grant_d)) begin
                    if_req_ready = grant_if;
                    d_req_ready  = grant_d;
                    state_nxt    = REQ;
                end
            end
            REQ: begin
                if (m_req_ready) begin
                    state_nxt = RSP;
                end
            end
            RSP: begin
                if (m_rsp_valid) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the winning request payload and owner; fetch and loads never carry byte enables.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_req_addr  <= '0;
            m_req_we    <= 1'b0;
            m_req_wstrb <= '0;
            m_req_wdata <= '0;
            owner       <= OWN_D;
        end else if (if_req_ready) begin
            m_req_addr  <= if_req_addr;
            m_req_we    <= 1'b0;
            m_req_wstrb <= '0;
            m_req_wdata <= '0;
            owner       <= OWN_IF;
        end else if (d_req_ready) begin
            m_req_addr  <= d_req_addr;
            m_req_we    <= d_req_we;
            m_req_wstrb <= d_req_we ? d_req_wstrb : '0;
            m_req_wdata <= d_req_wdata;
            owner       <= OWN_D;
        end
    end

    // Count data grants that bypass a waiting fetch; saturates so it can never wrap.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (if_req_ready) begin
            starve_cnt <= '0;
        end else if (d_req_ready && if_req_valid && (starve_cnt != CNT_W'(STARVE_MAX))) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Route the memory response to the owner only; a store ack returns zero data.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rsp_valid <= 1'b0;
            if_rsp_data  <= '0;
            d_rsp_valid  <= 1'b0;
            d_rsp_data   <= '0;
        end else begin
            if_rsp_valid <= 1'b0;
            d_rsp_valid  <= 1'b0;
            if ((state == RSP) && m_rsp_valid) begin
                if (owner == OWN_IF) begin
                    if_rsp_valid <= 1'b1;
                    if_rsp_data  <= m_rsp_data;
                end else begin
                    d_rsp_valid <= 1'b1;
                    d_rsp_data  <= m_req_we ? '0 : m_rsp_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences, random traffic.
// Latency: drives at posedge+1, samples at negedge.
// Backpressure: bench memory inserts random request stalls and response delays.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        reset;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_data;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_req_addr;
    logic        d_req_we;
    logic [3:0]  d_req_wstrb;
    logic [31:0] d_req_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_data;
    logic        m_req_valid;
    logic        m_req_ready;
    logic [31:0] m_req_addr;
    logic        m_req_we;
    logic [3:0]  m_req_wstrb;
    logic [31:0] m_req_wdata;
    logic        m_rsp_valid;
    logic [31:0] m_rsp_data;
    logic        busy;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_data  (if_rsp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_addr   (d_req_addr),
        .d_req_we     (d_req_we),
        .d_req_wstrb  (d_req_wstrb),
        .d_req_wdata  (d_req_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_data   (d_rsp_data),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_req_addr   (m_req_addr),
        .m_req_we     (m_req_we),
        .m_req_wstrb  (m_req_wstrb),
        .m_req_wdata  (m_req_wdata),
        .m_rsp_valid  (m_rsp_valid),
        .m_rsp_data   (m_rsp_data),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } rsp_t;

    typedef struct {
        logic       iv;
        logic       dv;
        logic       we;
        logic [3:0] ws;
        logic [1:0] g;    // expected {if_req_ready, d_req_ready}
        logic       ewe;
        logic [3:0] ews;
    } vec_t;

    int   errors  = 0;
    int   checks  = 0;
    logic sampled = 1'b0;
    rsp_t exp_q[$];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] outs();
        return {if_req_ready, if_rsp_valid, if_rsp_data, d_req_ready, d_rsp_valid, d_rsp_data,
                m_req_valid, m_req_addr, m_req_we, m_req_wstrb, m_req_wdata, busy};
    endfunction

    // Every response pulse must match the oldest expected response.
    task automatic mon();
        rsp_t e;
        if (if_rsp_valid || d_rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("rsp_spurious", {if_rsp_valid, d_rsp_valid}, 2'b00);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_port", {if_rsp_valid, d_rsp_valid}, e.is_d ? 2'b01 : 2'b10);
                chk("rsp_data", e.is_d ? d_rsp_data : if_rsp_data, e.data);
            end
        end
    endtask

    task automatic smp();
        @(negedge clk);
        mon();
        sampled = 1'b1;
    endtask

    task automatic step();
        if (!sampled) begin
            @(negedge clk);
            mon();
        end
        sampled = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic iv, input logic [31:0] ia, input logic dv, input logic [31:0] da,
                           input logic dwe, input logic [3:0] ds, input logic [31:0] dw);
        if_req_valid = iv;
        if_req_addr  = ia;
        d_req_valid  = dv;
        d_req_addr   = da;
        d_req_we     = dwe;
        d_req_wstrb  = ds;
        d_req_wdata  = dw;
    endtask

    task automatic do_reset();
        present(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        m_req_ready = 1'b0;
        m_rsp_valid = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Memory side of one transaction, entered in the cycle after the accept.
    task automatic mem_serve(input logic is_d, input logic [31:0] ea, input logic ewe, input logic [3:0] es,
                             input logic [31:0] ewd, input int stall, input int rdly,
                             input logic [31:0] rdata, input logic spur);
        rsp_t r;
        for (int i = 0; i < stall; i++) begin
            m_req_ready = 1'b0;
            m_rsp_valid = spur;
            m_rsp_data  = $urandom;
            smp();
            chk("req_payload", {m_req_valid, m_req_addr, m_req_we, m_req_wstrb, m_req_wdata},
                {1'b1, ea, ewe, es, ewd});
            chk("ready_hold", {if_req_ready, d_req_ready, busy}, 3'b001);
            step();
        end
        m_req_ready = 1'b1;
        m_rsp_valid = 1'b0;
        smp();
        chk("req_payload", {m_req_valid, m_req_addr, m_req_we, m_req_wstrb, m_req_wdata},
            {1'b1, ea, ewe, es, ewd});
        chk("ready_hold", {if_req_ready, d_req_ready, busy}, 3'b001);
        step();
        m_req_ready = 1'b0;
        for (int i = 0; i < rdly; i++) begin
            m_req_ready = spur;
            smp();
            chk("rsp_wait", {m_req_valid, busy}, 2'b01);
            step();
        end
        m_req_ready = 1'b0;
        m_rsp_valid = 1'b1;
        m_rsp_data  = rdata;
        r.is_d = is_d;
        r.data = (is_d && ewe) ? 32'h0 : rdata;
        exp_q.push_back(r);
        smp();
        chk("rsp_early", {if_rsp_valid, d_rsp_valid}, 2'b00);
        step();
        m_rsp_valid = 1'b0;
        m_rsp_data  = $urandom;
    endtask

    initial begin
        vec_t        tbl[8];
        logic        exp_if;
        logic        ip, dp, dwe, win_if, last_d;
        logic [31:0] ia, da, dwd;
        logic [3:0]  ds;
        int          cnt;

        m_rsp_data = 32'h0;
        reset      = 1'b1;
        present(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        m_req_ready = 1'b0;
        m_rsp_valid = 1'b0;
        #1;
        do_reset();

        // Reset state: every output low.
        smp();
        chk("reset_state", outs(), 160'h0);
        step();

        // Vector table, applied straight after reset (arbiter history starts fresh).
        tbl[0] = '{1'b1, 1'b0, 1'b0, 4'h0, 2'b10, 1'b0, 4'h0};
        tbl[1] = '{1'b0, 1'b1, 1'b0, 4'hF, 2'b01, 1'b0, 4'h0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 4'h5, 2'b01, 1'b1, 4'h5};
`ifdef MEM_ARB_RR_EN
        tbl[3] = '{1'b1, 1'b1, 1'b1, 4'h3, 2'b10, 1'b0, 4'h0};
`else
        tbl[3] = '{1'b1, 1'b1, 1'b1, 4'h3, 2'b01, 1'b1, 4'h3};
`endif
        tbl[4] = '{1'b0, 1'b0, 1'b0, 4'h0, 2'b00, 1'b0, 4'h0};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 4'h0, 2'b01, 1'b0, 4'h0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 4'h0, 2'b10, 1'b0, 4'h0};
        tbl[7] = '{1'b0, 1'b1, 1'b1, 4'h8, 2'b01, 1'b1, 4'h8};
        for (int i = 0; i < 8; i++) begin
            ia  = 32'h1000 + 32'(i * 4);
            da  = 32'h2000 + 32'(i * 16);
            dwd = 32'hC0DE0000 + 32'(i);
            present(tbl[i].iv, ia, tbl[i].dv, da, tbl[i].we, tbl[i].ws, dwd);
            smp();
            chk("tbl_grant", {if_req_ready, d_req_ready}, tbl[i].g);
            step();
            present(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
            if (tbl[i].g == 2'b10)
                mem_serve(1'b0, ia, 1'b0, 4'h0, 32'h0, 0, 0, $urandom, 1'b0);
            else if (tbl[i].g == 2'b01)
                mem_serve(1'b1, da, tbl[i].ewe, tbl[i].ews, dwd, 0, 0, $urandom, 1'b0);
        end

        // Fetch only, zero-wait memory: exact cycle timing.
        present(1'b1, 32'h10, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        smp();
        chk("t1_accept", {if_req_ready, d_req_ready, busy}, 3'b100);
        step();
        present(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        m_req_ready = 1'b1;
        smp();
        chk("t1_mreq", {m_req_valid, m_req_addr, m_req_we, m_req_wstrb, m_req_wdata},
            {1'b1, 32'h10, 1'b0, 4'h0, 32'h0});
        step();
        m_req_ready = 1'b0;
        m_rsp_valid = 1'b1;
        m_rsp_data  = 32'h00500093;
        exp_q.push_back('{1'b0, 32'h00500093});
        smp();
        chk("t1_rsp_t2", {if_rsp_valid, d_rsp_valid, m_req_valid}, 3'b000);
        step();
        m_rsp_valid = 1'b0;
        present(1'b1, 32'h14, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        smp();
        chk("t1_rsp_t3", {if_rsp_valid, if_rsp_data, d_rsp_valid}, {1'b1, 32'h00500093, 1'b0});
        chk("t1_next_accept", {if_req_ready, busy}, 2'b10);
        step();
        present(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        mem_serve(1'b0, 32'h14, 1'b0, 4'h0, 32'h0, 0, 0, 32'h00000013, 1'b0);

        // Store held off by memory for three cycles, ack data must be zero.
        present(1'b0, 32'h0, 1'b1, 32'h40, 1'b1, 4'hF, 32'hDEADBEEF);
        smp();
        chk("t2_accept", {if_req_ready, d_req_ready}, 2'b01);
        step();
        present(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        mem_serve(1'b1, 32'h40, 1'b1, 4'hF, 32'hDEADBEEF, 3, 0, 32'h5A5A5A5A, 1'b0);

        // Both ports held valid continuously from a fresh reset.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            ia  = 32'h100 + 32'(k * 4);
            da  = 32'h200 + 32'(k * 4);
            dwd = 32'hA0 + 32'(k);
            present(1'b1, ia, 1'b1, da, 1'b0, 4'h0, dwd);
`ifdef MEM_ARB_RR_EN
            exp_if = (k % 2 == 0);
`else
            exp_if = (k % 5 == 4);
`endif
            smp();
            chk("grant_seq", {if_req_ready, d_req_ready}, exp_if ? 2'b10 : 2'b01);
            step();
            if (exp_if)
                mem_serve(1'b0, ia, 1'b0, 4'h0, 32'h0, 0, 0, $urandom, 1'b0);
            else
                mem_serve(1'b1, da, 1'b0, 4'h0, dwd, 0, 0, $urandom, 1'b0);
        end
        present(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);

        // Reset while waiting for the response; the late response must vanish.
        present(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        smp();
        chk("t5_accept", {if_req_ready, d_req_ready}, 2'b10);
        step();
        present(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        m_req_ready = 1'b1;
        step();
        m_req_ready = 1'b0;
        reset = 1'b1;
        smp();
        chk("t5_in_rsp", {m_req_valid, busy}, 2'b01);
        step();
        reset = 1'b0;
        m_rsp_valid = 1'b1;
        m_rsp_data  = 32'hBAD0BAD0;
        smp();
        chk("t5_after_reset", outs(), 160'h0);
        step();
        m_rsp_valid = 1'b0;
        smp();
        chk("t5_late_rsp", outs(), 160'h0);
        step();

        // Random traffic against a transaction-level arbitration model.
        do_reset();
        ip = 1'b0;
        dp = 1'b0;
        ia = 32'h0;
        da = 32'h0;
        dwd = 32'h0;
        dwe = 1'b0;
        ds  = 4'h0;
        cnt = 0;
        last_d = 1'b1;
        for (int n = 0; n < 150; n++) begin
            if (ip && $urandom_range(7) == 0) ip = 1'b0;
            if (!ip && $urandom_range(1) == 1) begin
                ip = 1'b1;
                ia = $urandom;
            end
            if (!dp && $urandom_range(1) == 1) begin
                dp  = 1'b1;
                da  = $urandom;
                dwe = 1'($urandom_range(1));
                ds  = 4'($urandom_range(15));
                dwd = $urandom;
            end
            if (!ip && !dp) begin
                ip = 1'b1;
                ia = $urandom;
            end
            present(ip, ia, dp, da, dwe, ds, dwd);
`ifdef MEM_ARB_RR_EN
            win_if = ip && (!dp || last_d);
`else
            win_if = ip && (!dp || cnt == STARVE_MAX);
            if (win_if) cnt = 0;
            else if (ip) cnt++;
`endif
            last_d = !win_if;
            smp();
            chk("rand_grant", {if_req_ready, d_req_ready}, win_if ? 2'b10 : 2'b01);
            step();
            if (win_if) begin
                ip = 1'b0;
                if_req_valid = 1'b0;
                mem_serve(1'b0, ia, 1'b0, 4'h0, 32'h0, $urandom_range(3), $urandom_range(2),
                          $urandom, 1'($urandom_range(1)));
            end else begin
                dp = 1'b0;
                d_req_valid = 1'b0;
                mem_serve(1'b1, da, dwe, dwe ? ds : 4'h0, dwd, $urandom_range(3), $urandom_range(2),
                          $urandom, 1'($urandom_range(1)));
            end
        end
        present(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        step();
        step();
        chk("rsp_drain", 160'(exp_q.size()), 160'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
